event_encode42: RTL and testbench
=================================

# event_encode42

Registered 4-to-2 event encoder, the encode-side counterpart of the team's 2-to-4 one-hot decoder. Captures single-cycle event pulses on four request lines into a pending register. Emits each pending event as a 2-bit index over a valid/ready handshake, one index per transfer. Sits between event sources (buttons, timers, status strobes) and a consumer that decodes the index back to one-hot.

## Interface
- `RR`, default 0: 0 = fixed priority, bit 0 highest; 1 = round-robin, search starts after the last served index.
- `clk`  in  1  single clock, rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  4  event pulses, OR-ed into pending each cycle.
- `code`  out  2  encoded index of the presented event.
- `valid`  out  1  `code` is presented.
- `ready`  in  1  consumer accepts `code` when `valid & ready`.
- `pending`  out  4  current pending register.
- `err`  out  1  sticky: event arrived on an already-pending, unserved bit.
- `err_clr`  in  1  clears `err`.

## Operation
- Pending register P:
  - served = one-hot(code) when `valid & ready`, else 0.
  - P_next = (P & ~served) | req.
- Output FSM, two states:
  - IDLE: `valid`=0, `code`=00.
  - PRESENT: `valid`=1, `code` held stable.
- IDLE -> PRESENT when P != 0.
  - `code` = pick(P).
  - RR=0: lowest set bit.
  - RR=1: first set bit scanning last+1, last+2, … mod 4, wrapping 3 -> 0.
- PRESENT, `ready`=0: stay. `code` and `valid` unchanged. No preemption by newly arriving higher-priority bits.
- PRESENT, `ready`=1 (handshake):
  - `last` <= `code`.
  - If (P & ~served) != 0: stay PRESENT, `code` <= pick(P & ~served), using updated `last` in RR mode.
  - Else: go to IDLE.
- Selection never uses same-cycle `req`. It uses the registered P only.
- `err`:
  - Set when any req[i] & P[i] & ~served[i].
  - A req on the bit being served in the handshake cycle is a fresh event, not an error. That bit stays pending.
  - `err_clr` clears `err`. A simultaneous set wins over clear.
- `code` is 2'b00 whenever `valid`=0.

## Timing
- Reset values: P=0000, `valid`=0, `code`=00, `err`=0, `last`=11 (RR search begins at index 0).
- Reset is asynchronous. All outputs go to reset values immediately on `rst` assertion, including mid-transfer. Pending events are discarded.
- Latency from IDLE:
  - req high in cycle N -> `pending` bit visible in cycle N+1.
  - `valid`/`code` visible in cycle N+2.
- Throughput: one transfer per cycle with `ready` held high. No bubble between consecutive pending events.
- `pending` reflects P directly. The presented bit stays set until its handshake.

## Structure
- Shared package holds:
  - state enum {IDLE, PRESENT}
  - constant `NREQ`=4
  - constant `CODE_W`=2
- Sub-module `prio_pick4`: combinational.
  - Inputs: 4-bit vector, 2-bit base, rotate enable.
  - Outputs: 2-bit index, any-set flag.
- Top: P register, FSM, `last` pointer, `err` logic.

## Test plan
- Reset: hold `rst` -> `valid`=0, `code`=00, `pending`=0000, `err`=0. Release with `req`=0 -> outputs unchanged for 5 cycles.
- Fixed priority, RR=0, `ready`=1: `req`=1010 for one cycle N -> `code`=01 `valid`=1 at N+2; `code`=11 at N+3; `valid`=0, `pending`=0000 at N+4.
- Backpressure:
  - `req`=0100, `ready`=0 for 5 cycles -> `code`=10 held.
  - Inject `req`=0001 during the hold -> `code` stays 10, `pending`=0101.
  - Raise `ready` -> next cycle `code`=00, then IDLE.
- Error / simultaneous:
  - With bit 2 pending and unserved, `req`=0100 -> `err`=1, held until `err_clr`.
  - `req`=0100 during the bit-2 handshake -> `err` stays 0, `pending` keeps bit 2, `code`=10 presented again.
- Round-robin, RR=1, `ready`=1:
  - `req`=1111 -> codes 00,01,10,11 on consecutive cycles.
  - Then with `last`=00, `req`=0011 -> codes 01 then 00.
- Reset mid-operation: `valid`=1, `pending`=0110, assert `rst` asynchronously -> outputs zero before next edge. After release, no `valid` until a new `req`.

Source files
------------

// File: rtl/event_encode42_pkg.sv
// ---------------------------------------------------------------------------
// event_encode42_pkg
// Shared definitions for the registered 4-to-2 event encoder.
//   NREQ    : number of event request lines
//   CODE_W  : width of the encoded index
//   state_t : output FSM state (IDLE / PRESENT)
//   one_hot : turns an index back into a one-hot mask of NREQ bits
// ---------------------------------------------------------------------------
package event_encode42_pkg;

    localparam int NREQ   = 4;
    localparam int CODE_W = 2;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    function automatic logic [NREQ-1:0] one_hot(input logic [CODE_W-1:0] idx);
        logic [NREQ-1:0] mask;
        mask      = '0;
        mask[idx] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/event_encode42_prio_pick4.sv
// ---------------------------------------------------------------------------
// prio_pick4
// Combinational 4-way priority picker.
//   vec     in  4  candidate bits
//   base    in  2  last served index (used only when rotate=1)
//   rotate  in  1  0 = lowest set bit wins, 1 = search starts at base+1
//   idx     out 2  index of the winning bit (00 when nothing is set)
//   any_set out 1  at least one bit of vec is set
// ---------------------------------------------------------------------------
module prio_pick4
    import event_encode42_pkg::*;
(
    input  logic [NREQ-1:0]   vec,
    input  logic [CODE_W-1:0] base,
    input  logic              rotate,
    output logic [CODE_W-1:0] idx,
    output logic              any_set
);

    logic [CODE_W-1:0] cand;

    // Scan order is 0,1,2,3 in fixed mode, or base+1 .. base+4 (mod 4) in
    // rotating mode, so the last served index is considered last.
    always_comb begin
        idx     = '0;
        any_set = 1'b0;
        cand    = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = rotate ? CODE_W'(base + CODE_W'(i + 1)) : CODE_W'(i);
            if (!any_set && vec[cand]) begin
                idx     = cand;
                any_set = 1'b1;
            end
        end
    end

endmodule

// File: rtl/event_encode42.sv
// ---------------------------------------------------------------------------
// event_encode42
// Registered 4-to-2 event encoder. Single-cycle pulses on req are collected
// in a pending register and handed out one index per valid/ready transfer.
//   RR       param    0 = fixed priority (bit 0 highest), 1 = round-robin
//   clk      in  1    rising-edge clock
//   rst      in  1    asynchronous active-high reset
//   req      in  4    event pulses, OR-ed into pending every cycle
//   code     out 2    index of the presented event (00 while valid=0)
//   valid    out 1    code is presented
//   ready    in  1    consumer takes code when valid & ready
//   pending  out 4    current pending register
//   err      out 1    sticky: event hit an already pending, unserved bit
//   err_clr  in  1    clears err (a simultaneous new error wins)
// ---------------------------------------------------------------------------
module event_encode42
    import event_encode42_pkg::*;
#(
    parameter bit RR = 1'b0
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    output logic [CODE_W-1:0] code,
    output logic              valid,
    input  logic              ready,
    output logic [NREQ-1:0]   pending,
    output logic              err,
    input  logic              err_clr
);

    state_t            state_q, state_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic [CODE_W-1:0] last_q, last_d;
    logic [NREQ-1:0]   pend_q;
    logic              err_q;

    logic              handshake;
    logic [NREQ-1:0]   served;
    logic [NREQ-1:0]   remaining;
    logic [CODE_W-1:0] pick_base;
    logic [CODE_W-1:0] pick_idx;
    logic              pick_any;
    logic              err_set;

    assign handshake = (state_q == PRESENT) && ready;
    assign served    = handshake ? one_hot(code_q) : '0;
    assign remaining = pend_q & ~served;

    // While presenting, the next pick must already see the updated round-robin
    // pointer, which equals the code being handed over this cycle. From IDLE
    // nothing is served, so remaining equals the pending register.
    assign pick_base = (state_q == PRESENT) ? code_q : last_q;

    prio_pick4 u_pick (
        .vec     (remaining),
        .base    (pick_base),
        .rotate  (RR),
        .idx     (pick_idx),
        .any_set (pick_any)
    );

    // A request on the bit being served is a fresh event, so served bits are
    // excluded from the collision check.
    assign err_set = |(req & pend_q & ~served);

    // Pending register: served bit drops, new pulses are OR-ed in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
        end else begin
            pend_q <= remaining | req;
        end
    end

    // Sticky error flag; setting has priority over clearing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end else if (err_clr) begin
            err_q <= 1'b0;
        end
    end

    // FSM state, presented code and round-robin pointer. last resets to 11 so
    // the first round-robin search starts at index 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            code_q  <= '0;
            last_q  <= '1;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            last_q  <= last_d;
        end
    end

    // Next-state logic. A presented code is never preempted; a new pick only
    // happens on leaving IDLE or on a completed handshake, which gives
    // back-to-back transfers without a bubble while ready stays high.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = PRESENT;
                    code_d  = pick_idx;
                end
            end
            PRESENT: begin
                if (ready) begin
                    last_d = code_q;
                    if (pick_any) begin
                        code_d = pick_idx;
                    end else begin
                        state_d = IDLE;
                        code_d  = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                code_d  = '0;
            end
        endcase
    end

    assign valid   = (state_q == PRESENT);
    assign code    = valid ? code_q : '0;
    assign pending = pend_q;
    assign err     = err_q;

endmodule

// File: tb/tb_event_encode42.sv
// ---------------------------------------------------------------------------
// tb_event_encode42
// Self-checking bench for event_encode42. Two instances share clock and
// reset: dut0 in fixed-priority mode, dut1 in round-robin mode. Expected
// codes are queued when stimulus is issued; per-instance monitors pop and
// compare on every transfer. Inputs change 1 time unit after the rising
// edge, outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_event_encode42;
    import event_encode42_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req0, req1;
    logic        ready0, ready1;
    logic        err_clr0, err_clr1;
    logic [1:0]  code0, code1;
    logic        valid0, valid1;
    logic [3:0]  pending0, pending1;
    logic        err0, err1;

    int          assertCount = 0;
    int          failCount   = 0;
    logic [1:0]  q0[$];
    logic [1:0]  q1[$];

    event_encode42 #(.RR(1'b0)) dut0 (
        .clk     (clk),
        .rst     (rst),
        .req     (req0),
        .code    (code0),
        .valid   (valid0),
        .ready   (ready0),
        .pending (pending0),
        .err     (err0),
        .err_clr (err_clr0)
    );

    event_encode42 #(.RR(1'b1)) dut1 (
        .clk     (clk),
        .rst     (rst),
        .req     (req1),
        .code    (code1),
        .valid   (valid1),
        .ready   (ready1),
        .pending (pending1),
        .err     (err1),
        .err_clr (err_clr1)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int unit, input logic [3:0] r,
                                 input logic rdy, input logic clr);
        if (unit == 0) begin
            req0 = r; ready0 = rdy; err_clr0 = clr;
        end else begin
            req1 = r; ready1 = rdy; err_clr1 = clr;
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor for the fixed-priority instance: every transfer must match the
    // oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && valid0 && ready0) begin
            if (q0.size() == 0) begin
                checkOutput("dut0 unexpected transfer", 32'(code0), 32'hFF);
            end else begin
                checkOutput("dut0 transfer code", 32'(code0), 32'(q0.pop_front()));
            end
        end
    end

    // Monitor for the round-robin instance.
    always @(negedge clk) begin
        if (!rst && valid1 && ready1) begin
            if (q1.size() == 0) begin
                checkOutput("dut1 unexpected transfer", 32'(code1), 32'hFF);
            end else begin
                checkOutput("dut1 transfer code", 32'(code1), 32'(q1.pop_front()));
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        applyStimulus(0, 4'b0000, 1'b1, 1'b0);
        applyStimulus(1, 4'b0000, 1'b1, 1'b0);

        // Reset values while reset is held
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset valid0", 32'(valid0), 0);
        checkOutput("reset code0", 32'(code0), 0);
        checkOutput("reset pending0", 32'(pending0), 0);
        checkOutput("reset err0", 32'(err0), 0);
        checkOutput("reset valid1", 32'(valid1), 0);
        nextCycle();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("post-reset valid0", 32'(valid0), 0);
            checkOutput("post-reset pending0", 32'(pending0), 0);
            nextCycle();
        end

        // Fixed priority: req=1010 gives 01 then 11
        q0.push_back(2'b01);
        q0.push_back(2'b11);
        applyStimulus(0, 4'b1010, 1'b1, 1'b0);
        @(negedge clk); nextCycle();
        applyStimulus(0, 4'b0000, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("fixed N+1 pending", 32'(pending0), 32'b1010);
        checkOutput("fixed N+1 valid", 32'(valid0), 0);
        nextCycle();
        @(negedge clk);
        checkOutput("fixed N+2 valid", 32'(valid0), 1);
        checkOutput("fixed N+2 code", 32'(code0), 32'b01);
        nextCycle();
        @(negedge clk);
        checkOutput("fixed N+3 code", 32'(code0), 32'b11);
        checkOutput("fixed N+3 pending", 32'(pending0), 32'b1000);
        nextCycle();
        @(negedge clk);
        checkOutput("fixed N+4 valid", 32'(valid0), 0);
        checkOutput("fixed N+4 pending", 32'(pending0), 0);
        checkOutput("fixed N+4 code", 32'(code0), 0);
        nextCycle();

        // Backpressure with a higher-priority arrival during the hold
        q0.push_back(2'b10);
        applyStimulus(0, 4'b0100, 1'b0, 1'b0);
        @(negedge clk); nextCycle();
        applyStimulus(0, 4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("bp pending", 32'(pending0), 32'b0100);
        nextCycle();
        @(negedge clk);
        checkOutput("bp valid", 32'(valid0), 1);
        checkOutput("bp code", 32'(code0), 32'b10);
        nextCycle();
        q0.push_back(2'b00);
        applyStimulus(0, 4'b0001, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("bp hold code a", 32'(code0), 32'b10);
        nextCycle();
        applyStimulus(0, 4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("bp hold code b", 32'(code0), 32'b10);
        checkOutput("bp hold pending", 32'(pending0), 32'b0101);
        nextCycle();
        @(negedge clk);
        checkOutput("bp hold code c", 32'(code0), 32'b10);
        checkOutput("bp hold valid", 32'(valid0), 1);
        nextCycle();
        applyStimulus(0, 4'b0000, 1'b1, 1'b0);
        @(negedge clk);
        nextCycle();
        @(negedge clk);
        checkOutput("bp release code", 32'(code0), 32'b00);
        checkOutput("bp release valid", 32'(valid0), 1);
        checkOutput("bp release pending", 32'(pending0), 32'b0001);
        nextCycle();
        @(negedge clk);
        checkOutput("bp idle valid", 32'(valid0), 0);
        checkOutput("bp idle pending", 32'(pending0), 0);
        nextCycle();

        // Error on a pending, unserved bit; sticky until cleared
        q0.push_back(2'b10);
        applyStimulus(0, 4'b0100, 1'b0, 1'b0);
        @(negedge clk); nextCycle();
        applyStimulus(0, 4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("err pending", 32'(pending0), 32'b0100);
        nextCycle();
        applyStimulus(0, 4'b0100, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("err before", 32'(err0), 0);
        checkOutput("err present code", 32'(code0), 32'b10);
        nextCycle();
        applyStimulus(0, 4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("err set", 32'(err0), 1);
        checkOutput("err pending kept", 32'(pending0), 32'b0100);
        nextCycle();
        @(negedge clk);
        checkOutput("err sticky", 32'(err0), 1);
        nextCycle();
        applyStimulus(0, 4'b0000, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("err before clear edge", 32'(err0), 1);
        nextCycle();
        applyStimulus(0, 4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("err cleared", 32'(err0), 0);
        checkOutput("err still presenting", 32'(code0), 32'b10);
        nextCycle();

        // Re-request of the bit being served in the handshake cycle
        q0.push_back(2'b10);
        applyStimulus(0, 4'b0100, 1'b1, 1'b0);
        @(negedge clk);
        nextCycle();
        applyStimulus(0, 4'b0000, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("simul err", 32'(err0), 0);
        checkOutput("simul pending", 32'(pending0), 32'b0100);
        checkOutput("simul valid gap", 32'(valid0), 0);
        nextCycle();
        @(negedge clk);
        checkOutput("simul re-present valid", 32'(valid0), 1);
        checkOutput("simul re-present code", 32'(code0), 32'b10);
        checkOutput("simul err later", 32'(err0), 0);
        nextCycle();
        @(negedge clk);
        checkOutput("simul idle", 32'(valid0), 0);
        checkOutput("simul idle pending", 32'(pending0), 0);
        nextCycle();

        // Round-robin: all four at once from reset pointer 11
        q1.push_back(2'b00);
        q1.push_back(2'b01);
        q1.push_back(2'b10);
        q1.push_back(2'b11);
        applyStimulus(1, 4'b1111, 1'b1, 1'b0);
        @(negedge clk); nextCycle();
        applyStimulus(1, 4'b0000, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("rr pending", 32'(pending1), 32'b1111);
        nextCycle();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("rr burst valid", 32'(valid1), 1);
            checkOutput("rr burst code", 32'(code1), 32'(i));
            nextCycle();
        end
        @(negedge clk);
        checkOutput("rr burst end", 32'(valid1), 0);
        nextCycle();

        // Serve index 0 so the pointer becomes 00
        q1.push_back(2'b00);
        applyStimulus(1, 4'b0001, 1'b1, 1'b0);
        @(negedge clk); nextCycle();
        applyStimulus(1, 4'b0000, 1'b1, 1'b0);
        @(negedge clk); nextCycle();
        @(negedge clk);
        checkOutput("rr single code", 32'(code1), 32'b00);
        nextCycle();
        @(negedge clk);
        checkOutput("rr single idle", 32'(valid1), 0);
        nextCycle();

        // With pointer 00, req=0011 yields 01 then 00
        q1.push_back(2'b01);
        q1.push_back(2'b00);
        applyStimulus(1, 4'b0011, 1'b1, 1'b0);
        @(negedge clk); nextCycle();
        applyStimulus(1, 4'b0000, 1'b1, 1'b0);
        @(negedge clk); nextCycle();
        @(negedge clk);
        checkOutput("rr wrap first", 32'(code1), 32'b01);
        nextCycle();
        @(negedge clk);
        checkOutput("rr wrap second", 32'(code1), 32'b00);
        nextCycle();
        @(negedge clk);
        checkOutput("rr wrap idle", 32'(valid1), 0);
        nextCycle();

        // Asynchronous reset in the middle of a presentation
        applyStimulus(0, 4'b0110, 1'b0, 1'b0);
        @(negedge clk); nextCycle();
        applyStimulus(0, 4'b0000, 1'b0, 1'b0);
        @(negedge clk); nextCycle();
        @(negedge clk);
        checkOutput("mid valid before rst", 32'(valid0), 1);
        checkOutput("mid pending before rst", 32'(pending0), 32'b0110);
        checkOutput("mid code before rst", 32'(code0), 32'b01);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async rst valid", 32'(valid0), 0);
        checkOutput("async rst code", 32'(code0), 0);
        checkOutput("async rst pending", 32'(pending0), 0);
        checkOutput("async rst err", 32'(err0), 0);
        nextCycle();
        rst = 1'b0;
        applyStimulus(0, 4'b0000, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("after rst valid", 32'(valid0), 0);
            checkOutput("after rst pending", 32'(pending0), 0);
            nextCycle();
        end

        checkOutput("dut0 queue drained", 32'(q0.size()), 0);
        checkOutput("dut1 queue drained", 32'(q1.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
